// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the cache memory backend.
package cache_mem_pkg;

    localparam int unsigned LEN_W      = 16;
    localparam int unsigned RD_LAT_MAX = 15;
    localparam int unsigned LAT_W      = $clog2(RD_LAT_MAX + 1);

    typedef enum logic [2:0] {
        StIdle,
        StWrData,
        StWrDone,
        StRdWait,
        StRdData,
        StRdDone
    } cache_mem_state_e;

endpackage

// File: rtl/cache_mem_array.sv
// Single-port synchronous RAM; read data is registered and holds until the next read.
module cache_mem_array #(
    parameter int unsigned data_width = 32,
    parameter int unsigned mem_depth  = 1024,
    localparam int unsigned IdxW      = $clog2(mem_depth)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [IdxW-1:0]       addr,
    input  logic [data_width-1:0] wdata,
    output logic [data_width-1:0] rdata
);

    logic [data_width-1:0] mem [mem_depth];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/cache_mem_backend.sv
// Burst read/write memory backend: round-robin arbiter, one burst at a time, wrapping array index.
module cache_mem_backend
    import cache_mem_pkg::*;
#(
    parameter int unsigned data_width = 32,
    parameter int unsigned addr_width = 32,
    parameter int unsigned mem_depth  = 1024,
    parameter int unsigned rd_latency = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [LEN_W-1:0]      wr_len,
    output logic                  wr_gnt,
    input  logic                  wr_valid,
    input  logic [data_width-1:0] wr_data,
    input  logic                  wr_last,
    output logic                  wr_ready,
    output logic                  wr_done,
    input  logic                  rd_req,
    input  logic [addr_width-1:0] rd_addr,
    input  logic [LEN_W-1:0]      rd_len,
    output logic                  rd_gnt,
    output logic                  rd_valid,
    output logic [data_width-1:0] rd_data,
    input  logic                  rd_ready,
    output logic                  rd_done,
    output logic                  prot_err
);

    localparam int unsigned IDX_W = $clog2(mem_depth);

    cache_mem_state_e  state_q, state_d;
    logic              prio_rd_q, prio_rd_d;
    logic              wr_gnt_q, wr_gnt_d;
    logic              rd_gnt_q, rd_gnt_d;
    logic [IDX_W-1:0]  start_q, start_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              prot_err_q, prot_err_d;

    logic                  mem_en;
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_addr;
    logic [data_width-1:0] mem_rdata;
    logic                  arb_ok;
    logic                  grant_rd;
    logic                  grant_wr;
    logic                  beat_last;
    logic                  unused_addr;

    assign unused_addr = ^{wr_addr[addr_width-1:IDX_W], rd_addr[addr_width-1:IDX_W]};

    always_comb begin
        state_d    = state_q;
        prio_rd_d  = prio_rd_q;
        wr_gnt_d   = 1'b0;
        rd_gnt_d   = 1'b0;
        start_d    = start_q;
        len_d      = len_q;
        beat_d     = beat_q;
        lat_d      = lat_q;
        prot_err_d = prot_err_q;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = start_q + IDX_W'(beat_q);
        beat_last  = (beat_q == len_q - LEN_W'(1));
        // Done states also arbitrate so a new grant can follow a done pulse directly.
        arb_ok     = (state_q inside {StIdle, StWrDone, StRdDone});
        grant_rd   = arb_ok && rd_req && (!wr_req || prio_rd_q);
        grant_wr   = arb_ok && wr_req && !grant_rd;

        unique case (state_q)
            StIdle: ;
            StWrData: begin
                if (len_q == '0) begin
                    state_d = StWrDone;
                end else if (wr_valid && !wr_gnt_q) begin
                    mem_en = 1'b1;
                    mem_we = 1'b1;
                    beat_d = beat_q + LEN_W'(1);
                    if (wr_last != beat_last) prot_err_d = 1'b1;
                    if (beat_last) state_d = StWrDone;
                end
            end
            StRdWait: begin
                if (len_q == '0) begin
                    state_d = StRdDone;
                end else if (lat_q == LAT_W'(rd_latency - 1)) begin
                    mem_en  = 1'b1;
                    state_d = StRdData;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            StRdData: begin
                // Fetch the next word only on a handshake so rd_data holds while stalled.
                if (rd_ready) begin
                    if (beat_last) begin
                        state_d = StRdDone;
                    end else begin
                        beat_d   = beat_q + LEN_W'(1);
                        mem_en   = 1'b1;
                        mem_addr = start_q + IDX_W'(beat_q + LEN_W'(1));
                    end
                end
            end
            StWrDone, StRdDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (grant_rd) begin
            rd_gnt_d  = 1'b1;
            state_d   = StRdWait;
            start_d   = rd_addr[IDX_W-1:0];
            len_d     = rd_len;
            beat_d    = '0;
            lat_d     = '0;
            prio_rd_d = !prio_rd_q;
        end else if (grant_wr) begin
            wr_gnt_d  = 1'b1;
            state_d   = StWrData;
            start_d   = wr_addr[IDX_W-1:0];
            len_d     = wr_len;
            beat_d    = '0;
            lat_d     = '0;
            prio_rd_d = !prio_rd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            prio_rd_q  <= 1'b1;
            wr_gnt_q   <= 1'b0;
            rd_gnt_q   <= 1'b0;
            start_q    <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            lat_q      <= '0;
            prot_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_rd_q  <= prio_rd_d;
            wr_gnt_q   <= wr_gnt_d;
            rd_gnt_q   <= rd_gnt_d;
            start_q    <= start_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            lat_q      <= lat_d;
            prot_err_q <= prot_err_d;
        end
    end

    cache_mem_array #(
        .data_width(data_width),
        .mem_depth (mem_depth)
    ) u_array (
        .clk  (clk),
        .en   (mem_en),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(wr_data),
        .rdata(mem_rdata)
    );

    // The grant cycle is excluded so the first beat lands one cycle after wr_gnt.
    assign wr_ready = (state_q == StWrData) && !wr_gnt_q;
    assign wr_gnt   = wr_gnt_q;
    assign rd_gnt   = rd_gnt_q;
    assign wr_done  = (state_q == StWrDone);
    assign rd_done  = (state_q == StRdDone);
    assign rd_valid = (state_q == StRdData);
    assign rd_data  = rd_valid ? mem_rdata : '0;
    assign prot_err = prot_err_q;

endmodule

// File: tb/tb_cache_mem_backend.sv
// Scoreboard bench for cache_mem_backend: model memory, expected read-data queue, timing checks.
module tb_cache_mem_backend;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned RL    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_req, wr_gnt, wr_valid, wr_last, wr_ready, wr_done;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_len;
    logic [DW-1:0] wr_data;
    logic          rd_req, rd_gnt, rd_valid, rd_ready, rd_done, prot_err;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_len;
    logic [DW-1:0] rd_data;

    always #5 clk = ~clk;

    cache_mem_backend #(
        .data_width(DW),
        .addr_width(AW),
        .mem_depth (DEPTH),
        .rd_latency(RL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_req  (wr_req),
        .wr_addr (wr_addr),
        .wr_len  (wr_len),
        .wr_gnt  (wr_gnt),
        .wr_valid(wr_valid),
        .wr_data (wr_data),
        .wr_last (wr_last),
        .wr_ready(wr_ready),
        .wr_done (wr_done),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .rd_len  (rd_len),
        .rd_gnt  (rd_gnt),
        .rd_valid(rd_valid),
        .rd_data (rd_data),
        .rd_ready(rd_ready),
        .rd_done (rd_done),
        .prot_err(prot_err)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] exp_q [$];
    logic        exp_prot   = 1'b0;
    logic        exp_ptr_rd = 1'b1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every valid cycle must present the scoreboard head; a handshake retires it.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                check("rd_q_nonempty", 32'(exp_q.size()), 32'd1);
            end else begin
                check("rd_data", rd_data, exp_q[0]);
                if (rd_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic wr_burst(input int addr, input int len, input logic [31:0] d0,
                            input int last_at);
        int n;
        wr_addr = 32'(addr);
        wr_len  = 16'(len);
        wr_req  = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!wr_gnt && n < 20);
        check("wr_gnt_lat", 32'(n), 32'd1);
        wr_req     = 1'b0;
        exp_ptr_rd = !exp_ptr_rd;
        check("wr_ready_gnt", 32'(wr_ready), 32'd0);
        if (len == 0) begin
            wr_valid = 1'b1;
            wr_data  = 32'hDEAD_BEEF;
        end
        for (int i = 0; i < len; i++) begin
            tick();
            check("wr_ready", 32'(wr_ready), 32'd1);
            wr_valid = 1'b1;
            wr_data  = d0 + 32'(i);
            wr_last  = (i + 1 == last_at);
            model[(addr + i) % DEPTH] = d0 + 32'(i);
            if ((i + 1 == last_at) != (i + 1 == len)) exp_prot = 1'b1;
        end
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        check("wr_done", 32'(wr_done), 32'd1);
        check("wr_ready_done", 32'(wr_ready), 32'd0);
        tick();
        check("wr_done_pulse", 32'(wr_done), 32'd0);
        check("prot_err", 32'(prot_err), 32'(exp_prot));
    endtask

    task automatic rd_burst(input int addr, input int len, input logic [31:0] pat,
                            input int plen);
        int n;
        int hs;
        int j;
        int c;
        int exp_j;
        rd_addr = 32'(addr);
        rd_len  = 16'(len);
        rd_req  = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rd_gnt && n < 20);
        check("rd_gnt_lat", 32'(n), 32'd1);
        rd_req     = 1'b0;
        exp_ptr_rd = !exp_ptr_rd;
        for (int i = 0; i < len; i++) exp_q.push_back(model[(addr + i) % DEPTH]);
        check("rd_valid_gnt", 32'(rd_valid), 32'd0);
        for (int k = 1; k < int'(RL); k++) begin
            tick();
            check("rd_valid_wait", 32'(rd_valid), 32'd0);
        end
        tick();
        check("rd_first_valid", 32'(rd_valid), 32'd1);
        c = 0;
        exp_j = 0;
        while (c < len) begin
            if ((exp_j < plen) ? pat[exp_j] : 1'b1) c++;
            exp_j++;
        end
        hs = 0;
        j  = 0;
        while (hs < len && j < 64) begin
            rd_ready = (j < plen) ? pat[j] : 1'b1;
            if (rd_valid && rd_ready) hs++;
            tick();
            j++;
        end
        rd_ready = 1'b0;
        check("rd_handshakes", 32'(hs), 32'(len));
        check("rd_cycles", 32'(j), 32'(exp_j));
        check("rd_done", 32'(rd_done), 32'd1);
        check("rd_valid_end", 32'(rd_valid), 32'd0);
        tick();
        check("rd_done_pulse", 32'(rd_done), 32'd0);
        check("rd_q_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        int g;
        int dn;
        rst = 1'b1;
        {wr_req, wr_valid, wr_last, rd_req, rd_ready} = '0;
        wr_addr = '0; wr_len = '0; wr_data = '0; rd_addr = '0; rd_len = '0;
        repeat (3) tick();
        check("reset_outputs",
              32'({wr_gnt, wr_ready, wr_done, rd_gnt, rd_valid, rd_done, prot_err}), 32'd0);
        check("reset_rd_data", rd_data, 32'd0);
        rst = 1'b0;
        tick();

        // Both requests held across four zero-length bursts.
        wr_addr = 32'h40; wr_len = '0; rd_addr = 32'h40; rd_len = '0;
        wr_req = 1'b1; rd_req = 1'b1;
        g = 0;
        n = 0;
        while (g < 4 && n < 40) begin
            tick();
            n++;
            if (rd_gnt || wr_gnt) begin
                if (g == 0) check("arb_lat", 32'(n), 32'd1);
                check("gnt_onehot", 32'(rd_gnt && wr_gnt), 32'd0);
                check("gnt_order", 32'(rd_gnt), 32'(exp_ptr_rd));
                exp_ptr_rd = !exp_ptr_rd;
                g++;
            end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        check("gnt_count", 32'(g), 32'd4);
        tick();
        tick();

        wr_burst(32'h10, 4, 32'hA0, 4);
        rd_burst(32'h10, 4, 32'hFFFF_FFFF, 32);
        wr_burst(32'h10, 0, 32'h0, 0);
        rd_burst(32'h10, 3, 32'b11001, 5);

        wr_burst(DEPTH - 1, 2, 32'hB0, 1);
        rd_burst(DEPTH - 1, 2, 32'hFFFF_FFFF, 32);
        repeat (3) tick();
        check("prot_err_held", 32'(prot_err), 32'(exp_prot));

        // Reset during the second beat of a 4-beat read.
        rd_addr = 32'h10; rd_len = 16'd4; rd_req = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rd_gnt && n < 20);
        check("rst_rd_gnt", 32'(rd_gnt), 32'd1);
        rd_req = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(model[32'h10 + i]);
        repeat (RL) tick();
        rd_ready = 1'b1;
        tick();
        check("rst_beat2_valid", 32'(rd_valid), 32'd1);
        rst = 1'b1;
        tick();
        check("rst_mid_outputs",
              32'({wr_gnt, wr_ready, wr_done, rd_gnt, rd_valid, rd_done, prot_err}), 32'd0);
        check("rst_mid_rd_data", rd_data, 32'd0);
        rst      = 1'b0;
        rd_ready = 1'b0;
        exp_q.delete();
        exp_prot   = 1'b0;
        exp_ptr_rd = 1'b1;
        dn = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rd_done || rd_valid) dn++;
        end
        check("rst_no_done", 32'(dn), 32'd0);
        rd_burst(DEPTH - 1, 2, 32'hFFFF_FFFF, 32);
        wr_burst(32'h20, 1, 32'hC0, 1);
        rd_burst(32'h20, 1, 32'hFFFF_FFFF, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_mem_backend.md
# cache_mem_backend

Memory-side backend that sits directly downstream of the cache controller and serves its burst read and burst write channels: the `wr_*` and `rd_*` request/grant/data/done signals. It arbitrates between the two channels, runs one burst at a time against an internal word-addressed array, and signals completion. It is the synthesizable memory model used under the cache controller in block and top-level benches.

## Interface
- `data_width`, 32, beat width in bits
- `addr_width`, 32, word-address width
- `mem_depth`, 1024, array depth in words (power of two)
- `rd_latency`, 2, cycles from `rd_gnt` to first `rd_valid` (legal range 1..15)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `wr_req`  in  1  write burst request; held until `wr_gnt`
- `wr_addr`  in  addr_width  burst start word address; sampled on `wr_gnt`
- `wr_len`  in  16  beat count; sampled on `wr_gnt`
- `wr_gnt`  out  1  one-cycle grant pulse
- `wr_valid`  in  1  write beat valid
- `wr_data`  in  data_width  write beat data
- `wr_last`  in  1  marks final beat
- `wr_ready`  out  1  backend accepts beat
- `wr_done`  out  1  one-cycle pulse; burst committed
- `rd_req`  in  1  read burst request; held until `rd_gnt`
- `rd_addr`  in  addr_width  burst start address; sampled on `rd_gnt`
- `rd_len`  in  16  beat count; sampled on `rd_gnt`
- `rd_gnt`  out  1  one-cycle grant pulse
- `rd_valid`  out  1  read beat valid
- `rd_data`  out  data_width  read beat data
- `rd_ready`  in  1  consumer accepts beat
- `rd_done`  out  1  one-cycle pulse after final beat accepted
- `prot_err`  out  1  sticky; set on `wr_last` mismatch, cleared only by `rst`

## Operation
- FSM states: IDLE, WR_DATA, WR_DONE, RD_WAIT, RD_DATA, RD_DONE.
- IDLE with a request pending: assert the matching `*_gnt` for one cycle, latch addr and len, then move to WR_DATA or RD_WAIT.
- Both requests pending: round-robin between them. The priority pointer resets to read and flips after every grant.
- Array index = `(start + beat_cnt) mod mem_depth`, computed on the low `log2(mem_depth)` bits. Upper address bits are ignored, so bursts wrap at the array end.
- Write: `wr_ready` = 1 only in WR_DATA. Each `wr_valid && wr_ready` cycle writes one word and increments `beat_cnt`.
  - When the accepted beat is number `len`, go to WR_DONE.
  - `wr_last` present on any other beat, or absent on the final beat, sets `prot_err`. Beat counting continues regardless.
- RD_WAIT: count `rd_latency` cycles, then enter RD_DATA with `rd_valid` = 1.
- RD_DATA: `rd_data` is registered and stays stable while `rd_valid && !rd_ready`. The next word is presented the cycle after each handshake.
  - When the handshake is on beat `len`, go to RD_DONE.
- WR_DONE / RD_DONE: pulse `*_done` for one cycle, then return to IDLE.
- `len` = 0: grant, then skip the data phase. Go straight to *_DONE the cycle after grant.
- Array contents are not cleared by `rst`. They are undefined at power-on.

## Timing
- Reset value of every output is 0. The FSM resets to IDLE and `prot_err` is cleared.
- `rst` mid-burst: return to IDLE next cycle and drop the burst. Words already written stay written, and no `*_done` is issued.
- Grant latency: `*_gnt` rises in the cycle after `*_req` is first seen high in IDLE.
- Write: the earliest first beat is 1 cycle after `wr_gnt`. Sustained rate is 1 beat per cycle. `wr_done` comes 1 cycle after the last beat.
- Read: the first `rd_valid` comes exactly `rd_latency` cycles after `rd_gnt`. Rate is 1 beat per cycle with `rd_ready` held high. `rd_done` comes 1 cycle after the last handshake.
- Read-after-write: any write that has received `wr_done` is visible to a read granted afterwards.
- Back-to-back: a new grant is possible in the cycle after `*_done`. Minimum idle gap between bursts is 1 cycle.

## Structure
- Shared package `cache_mem_pkg`: state enum `cache_mem_state_e`, `LEN_W` = 16, and the `rd_latency` limit constant.
- Sub-module `cache_mem_array`: single-port synchronous RAM with 1-cycle read latency, parameterised by `data_width` and `mem_depth`.
- The backend holds the FSM, arbiter pointer, beat counter, latency counter and output registers.

## Test plan
- Write 4 beats at addr 0x10 (data 0xA0..0xA3, `wr_last` on beat 4), then read 4 from 0x10 with `rd_ready`=1. Expect: `rd_data` = 0xA0..0xA3 on consecutive cycles, first beat 2 cycles after `rd_gnt`, `rd_done` one cycle after the last beat, `prot_err`=0.
- Read 3 beats while `rd_ready` toggles 1,0,0,1,1. Expect: each beat held stable while stalled, exactly 3 handshakes, data in order.
- `rd_req` and `wr_req` both raised and held for 4 bursts. Expect grant order read, write, read, write.
- Write of len 2 from addr `mem_depth`-1 (0x3FF). Expect words at 0x3FF and 0x000. With `wr_last` on beat 1, expect `prot_err`=1 and held.
- `wr_len`=0. Expect `wr_gnt`, no `wr_ready` beat accepted, then `wr_done` 1 cycle after the grant.
- Assert `rst` in the middle of the second beat of a 4-beat read. Expect all outputs 0 next cycle, no `rd_done`, and a new request granted normally afterwards.
